alu_bist: RTL

Hardware stimulus/checker engine for the 8-bit `alu_all` datapath (`sel`: 0 add, 1 subtract, 2 AND, 3 OR). It drives the ALU operand/select inputs from an internal vector counter and samples `{cout, out}`. Each result is compared against a built-in reference model. It reports pass/fail, the first failing vector and an error count. It sits beside `alu_all` so that power-on and production self-test can sweep the full 2^(2·WIDTH+3) input space without a simulator.

---
 rtl/alu_bist_pkg.sv | 19 +
 rtl/alu_ref_model.sv | 41 ++++
 rtl/alu_bist.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_bist_pkg.sv
// Shared definitions for the alu_bist self-test engine and its reference model.
package alu_bist_pkg;

    localparam logic [1:0] SEL_ADD = 2'd0;
    localparam logic [1:0] SEL_SUB = 2'd1;
    localparam logic [1:0] SEL_AND = 2'd2;
    localparam logic [1:0] SEL_OR  = 2'd3;

    localparam int ERR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the alu_all datapath (add, sub, and, or).
module alu_ref_model
    import alu_bist_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] exp_out,
    output logic             exp_cout,
    output logic             cout_valid
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // MSB of the (WIDTH+1)-bit result is carry for add and borrow for sub
    assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};

    always_comb begin
        exp_out    = '0;
        exp_cout   = 1'b0;
        cout_valid = 1'b0;
        case (sel)
            SEL_ADD: begin
                {exp_cout, exp_out} = sum;
                cout_valid          = 1'b1;
            end
            SEL_SUB: begin
                {exp_cout, exp_out} = diff;
                cout_valid          = 1'b1;
            end
            SEL_AND: exp_out = a & b;
            default: exp_out = a | b;
        endcase
    end

endmodule

// File: rtl/alu_bist.sv
// Exhaustive stimulus/checker engine for alu_all: sweeps {sel, cin, b, a},
// compares against alu_ref_model and records pass, first failing vector, error count.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_DRIVE | register current vec onto the ALU inputs, load settle timer
// ST_WAIT  | settle timer counting down to 1
// ST_CHECK | compare ALU result, capture errors, advance or finish
// ST_DONE  | sweep finished, results held until start or abort
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SETTLE      = 1,
    parameter int STOP_ON_ERR = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic                 alu_cin,
    output logic [1:0]           alu_sel,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+2:0]   fail_vec,
    output logic [ERR_W-1:0]     err_count
);

    localparam int VW = 2*WIDTH + 3;
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [VW-1:0] VEC_LAST = {VW{1'b1}};

    state_t          state;
    state_t          state_nxt;
    logic [VW-1:0]   vec;
    logic [CW-1:0]   wait_cnt;
    logic [WIDTH-1:0] exp_out;
    logic            exp_cout;
    logic            cout_valid;
    logic            mismatch;
    logic            last_check;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a          (vec[WIDTH-1:0]),
        .b          (vec[2*WIDTH-1:WIDTH]),
        .cin        (vec[2*WIDTH]),
        .sel        (vec[2*WIDTH+2:2*WIDTH+1]),
        .exp_out    (exp_out),
        .exp_cout   (exp_cout),
        .cout_valid (cout_valid)
    );

    // Case inequality so an X/Z from the ALU is flagged rather than masked
    always_comb begin
        mismatch   = (alu_out !== exp_out) || (cout_valid && (alu_cout !== exp_cout));
        last_check = (mismatch && (STOP_ON_ERR != 0)) || (vec == VEC_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start) state_nxt = ST_DRIVE;
                ST_DRIVE:         state_nxt = ST_WAIT;
                ST_WAIT:          if (wait_cnt == CW'(1)) state_nxt = ST_CHECK;
                ST_CHECK:         state_nxt = last_check ? ST_DONE : ST_DRIVE;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            wait_cnt  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cin   <= 1'b0;
            alu_sel   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_vec  <= '0;
            err_count <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec       <= '0;
                        err_count <= '0;
                        fail_vec  <= '0;
                        pass      <= 1'b0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    alu_a    <= vec[WIDTH-1:0];
                    alu_b    <= vec[2*WIDTH-1:WIDTH];
                    alu_cin  <= vec[2*WIDTH];
                    alu_sel  <= vec[2*WIDTH+2:2*WIDTH+1];
                    wait_cnt <= CW'(SETTLE);
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
                        if (err_count == '0)            fail_vec  <= vec;
                    end
                    if (last_check) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= !mismatch && (err_count == '0);
                    end else begin
                        vec <= vec + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
